// File: rtl/bus_arbiter_pkg.sv
// Shared constants for bus_arbiter: bus widths, enable level, FSM encodings.
// BUS_ARB_ROUND_ROBIN_EN (in bus_arbiter.sv) selects round-robin instead of data priority.
package bus_arbiter_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam int DATA_ADDR_W = 32;
    localparam int DATA_W      = 32;

    localparam logic              CHIP_ENABLE = 1'b1;
    localparam logic [DATA_W-1:0] ZERO_WORD   = '0;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_IF_BUSY = 2'd1;
    localparam logic [1:0] S_D_BUSY  = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic SIDE_IF = 1'b0;
    localparam logic SIDE_D  = 1'b1;

endpackage

// File: rtl/bus_arbiter.sv
// Shares one memory port between instruction fetch and data access, with ack timeout.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed data priority.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_ce_i,
    input  logic [INST_ADDR_W-1:0] if_addr_i,
    output logic [INST_W-1:0]      if_data_o,
    output logic                   if_stallreq_o,
    input  logic                   d_ce_i,
    input  logic                   d_we_i,
    input  logic [3:0]             d_sel_i,
    input  logic [DATA_ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0]      d_data_i,
    output logic [DATA_W-1:0]      d_data_o,
    output logic                   d_stallreq_o,
    output logic                   bus_stb_o,
    output logic                   bus_we_o,
    output logic [3:0]             bus_sel_o,
    output logic [31:0]            bus_addr_o,
    output logic [31:0]            bus_data_o,
    input  logic [31:0]            bus_data_i,
    input  logic                   bus_ack_i,
    output logic                   err_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              served_q, served_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [INST_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] d_data_q, d_data_d;
    logic              err_q, err_d;
    logic              if_req, d_req, pick_d, busy, timeout;
    logic [31:0]       rd_val;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
`endif

    assign if_req  = (if_ce_i == CHIP_ENABLE);
    assign d_req   = (d_ce_i == CHIP_ENABLE);
    assign busy    = (state_q == S_IF_BUSY) || (state_q == S_D_BUSY);
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

`ifdef BUS_ARB_ROUND_ROBIN_EN
    // On a collision the side not served last goes first.
    assign pick_d = d_req && (!if_req || (last_q == SIDE_IF));
`else
    assign pick_d = d_req;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        served_d  = served_q;
        we_d      = we_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        if_data_d = if_data_q;
        d_data_d  = d_data_q;
        err_d     = 1'b0;
        rd_val    = ZERO_WORD;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (pick_d) begin
                    state_d  = S_D_BUSY;
                    served_d = SIDE_D;
                    addr_d   = d_addr_i;
                    we_d     = d_we_i;
                    sel_d    = d_sel_i;
                    wdata_d  = d_data_i;
                end else if (if_req) begin
                    state_d  = S_IF_BUSY;
                    served_d = SIDE_IF;
                    addr_d   = if_addr_i;
                    we_d     = 1'b0;
                    sel_d    = 4'b1111;
                    wdata_d  = ZERO_WORD;
                end
            end
            S_IF_BUSY, S_D_BUSY: begin
                // Ack wins over a coinciding timeout; a timeout completes with zero data.
                if (bus_ack_i || timeout) begin
                    state_d = S_DONE;
                    err_d   = !bus_ack_i;
                    rd_val  = bus_ack_i ? bus_data_i : ZERO_WORD;
                    if (state_q == S_IF_BUSY) if_data_d = rd_val;
                    else if (!we_q)           d_data_d  = rd_val;
`ifdef BUS_ARB_ROUND_ROBIN_EN
                    last_d = served_q;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            served_q  <= SIDE_IF;
            we_q      <= 1'b0;
            sel_q     <= 4'b0000;
            addr_q    <= '0;
            wdata_q   <= '0;
            if_data_q <= ZERO_WORD;
            d_data_q  <= ZERO_WORD;
            err_q     <= 1'b0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            last_q    <= SIDE_IF;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            served_q  <= served_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            if_data_q <= if_data_d;
            d_data_q  <= d_data_d;
            err_q     <= err_d;
`ifdef BUS_ARB_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

    assign bus_stb_o     = busy;
    assign bus_we_o      = we_q;
    assign bus_sel_o     = sel_q;
    assign bus_addr_o    = addr_q;
    assign bus_data_o    = wdata_q;
    assign err_o         = err_q;
    assign if_data_o     = if_data_q;
    assign d_data_o      = d_data_q;
    assign if_stallreq_o = !rst && if_req && !((state_q == S_DONE) && (served_q == SIDE_IF));
    assign d_stallreq_o  = !rst && d_req  && !((state_q == S_DONE) && (served_q == SIDE_D));

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed table, hand sequences, randomized transactions.
module tb_bus_arbiter;

    localparam int TO = 4;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce_i, d_ce_i, d_we_i, bus_ack_i;
    logic [31:0] if_addr_i, d_addr_i, d_data_i, bus_data_i;
    logic [3:0]  d_sel_i;
    logic [31:0] if_data_o, d_data_o, bus_addr_o, bus_data_o;
    logic [3:0]  bus_sel_o;
    logic        if_stallreq_o, d_stallreq_o, bus_stb_o, bus_we_o, err_o;

    bus_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .if_ce_i(if_ce_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_stallreq_o(if_stallreq_o),
        .d_ce_i(d_ce_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i), .d_addr_i(d_addr_i), .d_data_i(d_data_i),
        .d_data_o(d_data_o), .d_stallreq_o(d_stallreq_o),
        .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
        .bus_data_o(bus_data_o), .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level reference: read registers and the side that completed last.
    logic [31:0] m_ifd = 0, m_dd = 0;
    bit          m_last_d = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit win_d(input bit ic, input bit dc);
        if (ic && dc) return RR ? !m_last_d : 1'b1;
        return dc;
    endfunction

    // Serve one granted transfer; called at a negedge with requests driven.
    task automatic serve(input bit side_d, input int dly, input logic [31:0] rd);
        int n = 0;
        int last;
        while (bus_stb_o !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        if (bus_stb_o !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL grant_wait: no stb within 10 cycles");
            return;
        end
        chk("bus_addr", bus_addr_o, side_d ? d_addr_i : if_addr_i);
        chk("bus_we",   {31'b0, bus_we_o}, side_d ? {31'b0, d_we_i} : 32'd0);
        chk("bus_sel",  {28'b0, bus_sel_o}, side_d ? {28'b0, d_sel_i} : 32'hF);
        if (side_d) chk("bus_wdata", bus_data_o, d_data_i);
        chk("stall_busy", {31'b0, side_d ? d_stallreq_o : if_stallreq_o}, 32'd1);
        last = (dly < TO) ? dly : TO - 1;
        for (int c = 0; c <= last; c++) begin
            if (c == dly) begin bus_ack_i = 1'b1; bus_data_i = rd; end
            @(negedge clk);
            bus_ack_i = 1'b0;
            if (c < last) chk("stb_held", {31'b0, bus_stb_o}, 32'd1);
        end
        if (!side_d) m_ifd = (dly < TO) ? rd : 32'd0;
        else if (!d_we_i) m_dd = (dly < TO) ? rd : 32'd0;
        m_last_d = side_d;
        chk("done_stb", {31'b0, bus_stb_o}, 32'd0);
        chk("done_err", {31'b0, err_o}, (dly >= TO) ? 32'd1 : 32'd0);
        chk("done_stall", {31'b0, side_d ? d_stallreq_o : if_stallreq_o}, 32'd0);
        if (side_d ? if_ce_i : d_ce_i)
            chk("other_stall", {31'b0, side_d ? if_stallreq_o : d_stallreq_o}, 32'd1);
        chk("if_data", if_data_o, m_ifd);
        chk("d_data", d_data_o, m_dd);
        if (side_d) d_ce_i = 1'b0; else if_ce_i = 1'b0;
        @(negedge clk);
        chk("err_pulse_end", {31'b0, err_o}, 32'd0);
    endtask

    task automatic txn(input bit ic, input bit dc, input bit we, input logic [3:0] sel,
                       input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                       input int dly, input logic [31:0] rd, input bit first_d);
        if_ce_i = ic; if_addr_i = ia;
        d_ce_i = dc; d_we_i = we; d_sel_i = sel; d_addr_i = da; d_data_i = wd;
        serve(first_d, dly, rd);
        if (ic && dc) serve(!first_d, dly, rd);
    endtask

    typedef struct {
        bit          ic, dc, we;
        logic [3:0]  sel;
        logic [31:0] ia, da, wd;
        int          dly;
        logic [31:0] rd;
        bit          exp_first_d;
        logic [31:0] exp_ifd, exp_dd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1, 0, 0, 4'hF, 32'h10, 32'h0,   32'h0,        2, 32'h3401_1100, 0,   32'h3401_1100, 32'h0};
        vecs[1] = '{1, 1, 1, 4'h3, 32'h14, 32'h80,  32'hDEAD_BEEF, 1, 32'h1111_2222, 1,   32'h1111_2222, 32'h0};
        vecs[2] = '{0, 1, 0, 4'hF, 32'h0,  32'h100, 32'h0,        9, 32'h9999_9999, 1,   32'h1111_2222, 32'h0};
        vecs[3] = '{0, 1, 0, 4'hF, 32'h0,  32'h104, 32'h0,        0, 32'hCAFE_F00D, 1,   32'h1111_2222, 32'hCAFE_F00D};
        vecs[4] = '{1, 0, 0, 4'hF, 32'h18, 32'h0,   32'h0,        5, 32'h5555_5555, 0,   32'h0,         32'hCAFE_F00D};
        vecs[5] = '{1, 1, 0, 4'hC, 32'h20, 32'h200, 32'h0,        3, 32'h5A5A_0000, 1,   32'h5A5A_0000, 32'h5A5A_0000};
        vecs[6] = '{0, 1, 0, 4'hF, 32'h0,  32'h300, 32'h0,        1, 32'h0102_0304, 1,   32'h5A5A_0000, 32'h0102_0304};
        vecs[7] = '{1, 1, 1, 4'h3, 32'h24, 32'h80,  32'h0000_BEEF, 0, 32'h7777_8888, !RR, 32'h7777_8888, 32'h0102_0304};

        rst = 1'b1; bus_ack_i = 1'b0; bus_data_i = 0;
        if_ce_i = 1'b1; d_ce_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'hF;
        if_addr_i = 32'h44; d_addr_i = 32'h88; d_data_i = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        chk("rst_stb", {31'b0, bus_stb_o}, 32'd0);
        chk("rst_we", {31'b0, bus_we_o}, 32'd0);
        chk("rst_sel", {28'b0, bus_sel_o}, 32'd0);
        chk("rst_addr", bus_addr_o, 32'd0);
        chk("rst_wdata", bus_data_o, 32'd0);
        chk("rst_err", {31'b0, err_o}, 32'd0);
        chk("rst_if_data", if_data_o, 32'd0);
        chk("rst_d_data", d_data_o, 32'd0);
        chk("rst_if_stall", {31'b0, if_stallreq_o}, 32'd0);
        chk("rst_d_stall", {31'b0, d_stallreq_o}, 32'd0);
        if_ce_i = 1'b0; d_ce_i = 1'b0; d_we_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            txn(vecs[i].ic, vecs[i].dc, vecs[i].we, vecs[i].sel, vecs[i].ia, vecs[i].da,
                vecs[i].wd, vecs[i].dly, vecs[i].rd, vecs[i].exp_first_d);
            chk($sformatf("vec%0d_if_data", i), if_data_o, vecs[i].exp_ifd);
            chk($sformatf("vec%0d_d_data", i), d_data_o, vecs[i].exp_dd);
        end

        // Ack while idle must be ignored.
        bus_ack_i = 1'b1; bus_data_i = 32'hFFFF_0000;
        repeat (2) @(negedge clk);
        bus_ack_i = 1'b0;
        chk("idle_ack_stb", {31'b0, bus_stb_o}, 32'd0);
        chk("idle_ack_if", if_data_o, m_ifd);
        chk("idle_ack_d", d_data_o, m_dd);

        // Back-to-back fetches with ack present from the first stb cycle.
        if_ce_i = 1'b1; bus_ack_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if_addr_i = 32'h1000 + 32'(4 * k);
            bus_data_i = 32'hA000_0000 + 32'(k);
            @(negedge clk);
            chk("b2b_stb", {31'b0, bus_stb_o}, 32'd1);
            chk("b2b_addr", bus_addr_o, 32'h1000 + 32'(4 * k));
            @(negedge clk);
            chk("b2b_done_stb", {31'b0, bus_stb_o}, 32'd0);
            chk("b2b_data", if_data_o, 32'hA000_0000 + 32'(k));
            chk("b2b_stall", {31'b0, if_stallreq_o}, 32'd0);
            @(negedge clk);
            chk("b2b_idle_stb", {31'b0, bus_stb_o}, 32'd0);
            m_ifd = 32'hA000_0000 + 32'(k);
            m_last_d = 1'b0;
        end
        if_ce_i = 1'b0; bus_ack_i = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset during a fetch, then a late ack.
        if_ce_i = 1'b1; if_addr_i = 32'h40;
        begin
            int n = 0;
            while (bus_stb_o !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        end
        chk("mid_stb_before", {31'b0, bus_stb_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_stb", {31'b0, bus_stb_o}, 32'd0);
        chk("mid_rst_addr", bus_addr_o, 32'd0);
        chk("mid_rst_if_data", if_data_o, 32'd0);
        chk("mid_rst_d_data", d_data_o, 32'd0);
        chk("mid_rst_stall", {31'b0, if_stallreq_o}, 32'd0);
        rst = 1'b0; if_ce_i = 1'b0;
        bus_ack_i = 1'b1; bus_data_i = 32'h1234_5678;
        repeat (2) @(negedge clk);
        bus_ack_i = 1'b0;
        chk("late_ack_stb", {31'b0, bus_stb_o}, 32'd0);
        chk("late_ack_if", if_data_o, 32'd0);
        chk("late_ack_err", {31'b0, err_o}, 32'd0);
        m_ifd = 0; m_dd = 0; m_last_d = 1'b0;

        for (int i = 0; i < 40; i++) begin
            bit ic, dc;
            ic = 1'($urandom_range(0, 1));
            dc = 1'($urandom_range(0, 1));
            if (!ic && !dc) ic = 1'b1;
            txn(ic, dc, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom, $urandom,
                int'($urandom_range(0, 5)), $urandom, win_d(ic, dc));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
